// File: rtl/fetch_stage_if.sv
// ----------------------------------------------------------------------------
// fetch_stage_if
//   Instruction-memory request/response bus between the fetch stage and the
//   instruction memory. One request may be outstanding; responses return in
//   order, at least one cycle after the grant.
//
//   imem_req     request valid (fetch -> memory)
//   imem_addr    word-aligned request address (fetch -> memory)
//   imem_gnt     memory accepts the request this cycle (memory -> fetch)
//   imem_rvalid  response valid (memory -> fetch)
//   imem_rdata   response instruction word (memory -> fetch)
//
//   modport master : used by the fetch stage
//   modport slave  : used by the instruction memory
// ----------------------------------------------------------------------------
interface fetch_stage_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_gnt,
        input  imem_rvalid,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_gnt,
        output imem_rvalid,
        output imem_rdata
    );
endinterface

// File: rtl/fetch_stage.sv
// ----------------------------------------------------------------------------
// fetch_stage
//   Instruction-fetch stage plus the IF/ID pipeline register. Holds the fetch
//   PC, issues instruction-memory requests with at most one outstanding,
//   keeps a one-entry buffer for a response that arrives while decode is
//   stalled, and presents InstrD/PCD/PCPlus4D/ValidD to decode. A taken
//   redirect from EX (PCSrcE) flushes IF/ID and restarts fetch at PCTargetE.
//
// Parameters
//   RESET_PC    first fetch address after reset
//   NOP_INSTR   bubble loaded into IF/ID (addi x0,x0,0)
//
// Ports
//   clk         clock, all state on the rising edge
//   rst         asynchronous, active-low reset
//   stall       load-use stall from the hazard unit: hold PC and IF/ID
//   PCSrcE      redirect taken in EX this cycle (wins over stall)
//   PCTargetE   redirect target, bits [1:0] ignored
//   imem        instruction-memory bus (fetch_stage_if.master)
//   InstrD      IF/ID instruction
//   PCD         IF/ID PC (address of InstrD)
//   PCPlus4D    IF/ID PC + 4, 32-bit wrap
//   ValidD      IF/ID holds a real instruction (0 = bubble)
//
// Optional feature (macro FETCH_PERF_EN)
//   perf_stall_cnt  cycles with stall = 1, wraps at 2^32
//   perf_flush_cnt  cycles with PCSrcE = 1, wraps at 2^32
//   Without the macro these ports and counters do not exist.
// ----------------------------------------------------------------------------
module fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 stall,
    input  logic                 PCSrcE,
    input  logic [31:0]          PCTargetE,
    fetch_stage_if.master        imem,
    output logic [31:0]          InstrD,
    output logic [31:0]          PCD,
    output logic [31:0]          PCPlus4D,
    output logic                 ValidD
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0]          perf_stall_cnt,
    output logic [31:0]          perf_flush_cnt
`endif
);

    typedef enum logic [1:0] {
        S_IDLE, // one cycle after reset release
        S_REQ,  // requesting pc_f, waiting for grant
        S_WAIT, // granted, waiting for the response of req_pc
        S_KILL  // granted request made stale by a redirect, drop its response
    } state_t;

    state_t      state;
    logic [31:0] pc_f;      // next address to request (also the redirect target held in KILL)
    logic [31:0] req_pc;    // address of the granted, outstanding request
    logic        buf_valid;
    logic [31:0] buf_instr;
    logic [31:0] buf_pc;

    logic [31:0] target;
    logic [31:0] next_pc;
    logic        rsp;
    logic        chain;
    logic        grant;
    logic        buf_fill;
    logic        unused_tgt_lsb;

    // Instructions are word aligned; the low target bits carry no information.
    assign target         = {PCTargetE[31:2], 2'b00};
    assign unused_tgt_lsb = ^PCTargetE[1:0];

    assign next_pc  = req_pc + 32'd4;

    // A response only counts while its request is live; in KILL it is dropped.
    assign rsp      = (state == S_WAIT) && imem.imem_rvalid;

    // Back-to-back issue: the response is going straight into IF/ID, so the
    // next request can go out in the same cycle. This is what lets a
    // zero-wait memory sustain one instruction per cycle, and it is why the
    // request is decoded from the state rather than registered.
    assign chain    = rsp && !stall && !PCSrcE && !buf_valid;

    // No request while the buffer is occupied: there would be nowhere to put
    // the answer if decode stays stalled.
    assign imem.imem_req  = ((state == S_REQ) && !buf_valid) || chain;
    assign imem.imem_addr = (state == S_WAIT) ? next_pc : pc_f;
    assign grant          = imem.imem_req && imem.imem_gnt;

    assign buf_fill = rsp && stall && !PCSrcE;

    // ------------------------------------------------------------------
    // Fetch FSM and PC tracking
    // ------------------------------------------------------------------
    // NOTE: sequential state is written with non-blocking assignments so every
    // register samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= S_IDLE;
            pc_f   <= RESET_PC;
            req_pc <= RESET_PC;
        end else begin
            case (state)
                S_IDLE: begin
                    state <= S_REQ;
                    if (PCSrcE) pc_f <= target;
                end

                S_REQ: begin
                    if (PCSrcE) begin
                        // Not yet granted: simply retarget. Granted: the
                        // address already left, so its response must be eaten.
                        pc_f <= target;
                        if (grant) state <= S_KILL;
                    end else if (grant) begin
                        req_pc <= pc_f;
                        state  <= S_WAIT;
                    end
                end

                S_WAIT: begin
                    if (PCSrcE) begin
                        pc_f  <= target;
                        state <= imem.imem_rvalid ? S_REQ : S_KILL;
                    end else if (imem.imem_rvalid) begin
                        pc_f <= next_pc;
                        if (grant) begin
                            req_pc <= next_pc;
                            state  <= S_WAIT;
                        end else begin
                            state  <= S_REQ;
                        end
                    end
                end

                S_KILL: begin
                    // A further redirect while waiting just moves the restart point.
                    if (PCSrcE) pc_f <= target;
                    if (imem.imem_rvalid) state <= S_REQ;
                end

                default: state <= S_IDLE;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // IF/ID register and buffer occupancy
    // Priority: redirect > stall > buffered instruction > live response > bubble
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            InstrD    <= NOP_INSTR;
            PCD       <= 32'd0;
            PCPlus4D  <= 32'd0;
            ValidD    <= 1'b0;
            buf_valid <= 1'b0;
        end else if (PCSrcE) begin
            InstrD    <= NOP_INSTR;
            PCD       <= 32'd0;
            PCPlus4D  <= 32'd0;
            ValidD    <= 1'b0;
            buf_valid <= 1'b0;
        end else if (stall) begin
            if (buf_fill) buf_valid <= 1'b1;
        end else if (buf_valid) begin
            InstrD    <= buf_instr;
            PCD       <= buf_pc;
            PCPlus4D  <= buf_pc + 32'd4;
            ValidD    <= 1'b1;
            buf_valid <= 1'b0;
        end else if (rsp) begin
            InstrD    <= imem.imem_rdata;
            PCD       <= req_pc;
            PCPlus4D  <= next_pc;
            ValidD    <= 1'b1;
        end else begin
            InstrD    <= NOP_INSTR;
            PCD       <= 32'd0;
            PCPlus4D  <= 32'd0;
            ValidD    <= 1'b0;
        end
    end

    // NOTE: the buffer payload has no reset; buf_valid alone decides whether it
    // is ever read, so clearing the data would only cost reset fan-out.
    always_ff @(posedge clk) begin
        if (buf_fill) begin
            buf_instr <= imem.imem_rdata;
            buf_pc    <= req_pc;
        end
    end

`ifdef FETCH_PERF_EN
    // ------------------------------------------------------------------
    // Performance counters, free-running with natural 32-bit wrap
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            perf_stall_cnt <= 32'd0;
            perf_flush_cnt <= 32'd0;
        end else begin
            if (stall)  perf_stall_cnt <= perf_stall_cnt + 32'd1;
            if (PCSrcE) perf_flush_cnt <= perf_flush_cnt + 32'd1;
        end
    end
`endif

endmodule
